// File: rtl/key_debouncer.sv
// Multi-key debouncer: turns the divider's slow square wave into a sample tick and
// accepts a new key level only after it has held for STABLE_TICKS consecutive ticks.
module key_debouncer #(
    parameter int NUM_KEYS     = 4,
    parameter int STABLE_TICKS = 320,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                tick_clk,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_state,
    output logic [NUM_KEYS-1:0] keys_press,
    output logic [NUM_KEYS-1:0] keys_release
);

    localparam int              CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic                tick_clk_d;
    logic                tick;
    logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] sync;

    // The delay flop resets high so a tick_clk already high at reset release is not an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_clk_d <= 1'b1;
        end else begin
            tick_clk_d <= tick_clk;
        end
    end

    assign tick = tick_clk & ~tick_clk_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= keys_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             state_q;
        logic             state_nxt;
        logic             press_q;
        logic             press_nxt;
        logic             release_q;
        logic             release_nxt;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            cnt_nxt     = cnt;
            state_nxt   = state_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            if (sync[i] == state_q) begin
                cnt_nxt = '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    state_nxt   = sync[i];
                    press_nxt   = sync[i];
                    release_nxt = ~sync[i];
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt       <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                cnt       <= cnt_nxt;
                state_q   <= state_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        assign keys_state[i]   = state_q;
        assign keys_press[i]   = press_q;
        assign keys_release[i] = release_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed table and latency sequences plus random stimulus
// compared every cycle against a tick-counting reference model.
module tb_key_debouncer;

    localparam int NUM_KEYS     = 4;
    localparam int STABLE_TICKS = 4;
    localparam int SYNC_STAGES  = 2;

    logic                clk_in;
    logic                reset_n;
    logic                tick_clk;
    logic [NUM_KEYS-1:0] keys_in;
    logic [NUM_KEYS-1:0] keys_state;
    logic [NUM_KEYS-1:0] keys_press;
    logic [NUM_KEYS-1:0] keys_release;

    key_debouncer #(
        .NUM_KEYS    (NUM_KEYS),
        .STABLE_TICKS(STABLE_TICKS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .tick_clk    (tick_clk),
        .keys_in     (keys_in),
        .keys_state  (keys_state),
        .keys_press  (keys_press),
        .keys_release(keys_release)
    );

    int n_vec = 0;
    int n_err = 0;

    logic tick_stop = 1'b0;

    logic [NUM_KEYS-1:0] acc_press;
    logic [NUM_KEYS-1:0] acc_release;
    int                  pulse_cycles;

    // Reference model state
    logic [NUM_KEYS-1:0] m_state;
    logic [NUM_KEYS-1:0] m_press;
    logic [NUM_KEYS-1:0] m_release;
    logic [NUM_KEYS-1:0] m_hist[$];
    int                  m_ticks[NUM_KEYS];
    logic                m_prev;
    int                  tick_count = 0;

    typedef struct {
        logic [NUM_KEYS-1:0] keys;
        int                  ticks;
        logic [NUM_KEYS-1:0] exp_state;
        logic [NUM_KEYS-1:0] exp_press;
        logic [NUM_KEYS-1:0] exp_release;
    } step_t;

    step_t steps[6];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // tick_clk toggles every 4 cycles; while stalled it is held high
    initial begin
        int phase;
        phase    = 0;
        tick_clk = 1'b1;
        forever begin
            @(negedge clk_in);
            if (tick_stop) begin
                tick_clk = 1'b1;
                phase    = 0;
            end else begin
                phase++;
                if (phase == 4) begin
                    phase    = 0;
                    tick_clk = ~tick_clk;
                end
            end
        end
    end

    // Model: a key's new level is accepted once STABLE_TICKS sample ticks have been
    // seen while the synchronized level continuously differs from the accepted one.
    initial begin
        logic                tick_now;
        logic [NUM_KEYS-1:0] sync_now;
        m_state   = '0;
        m_press   = '0;
        m_release = '0;
        m_prev    = 1'b1;
        foreach (m_ticks[k]) m_ticks[k] = 0;
        repeat (SYNC_STAGES) m_hist.push_back('0);
        forever begin
            @(posedge clk_in or negedge reset_n);
            if (!reset_n) begin
                m_state   = '0;
                m_press   = '0;
                m_release = '0;
                m_prev    = 1'b1;
                foreach (m_ticks[k]) m_ticks[k] = 0;
                m_hist.delete();
                repeat (SYNC_STAGES) m_hist.push_back('0);
            end else begin
                tick_now = tick_clk && !m_prev;
                m_prev   = tick_clk;
                sync_now = m_hist[SYNC_STAGES-1];
                m_hist.push_front(keys_in);
                void'(m_hist.pop_back());
                if (tick_now) tick_count++;
                m_press   = '0;
                m_release = '0;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (sync_now[k] == m_state[k]) begin
                        m_ticks[k] = 0;
                    end else if (tick_now) begin
                        m_ticks[k]++;
                        if (m_ticks[k] == STABLE_TICKS) begin
                            m_state[k]   = sync_now[k];
                            m_press[k]   = sync_now[k];
                            m_release[k] = !sync_now[k];
                            m_ticks[k]   = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            check("model_state", 32'(keys_state), 32'(m_state));
            check("model_press", 32'(keys_press), 32'(m_press));
            check("model_release", 32'(keys_release), 32'(m_release));
        end
    end

    task automatic reset_acc();
        acc_press    = '0;
        acc_release  = '0;
        pulse_cycles = 0;
    endtask

    task automatic sample_acc();
        acc_press   = acc_press | keys_press;
        acc_release = acc_release | keys_release;
        if ((keys_press | keys_release) != '0) pulse_cycles++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk_in);
            sample_acc();
        end
    endtask

    // Returns on the falling edge right after the n-th further sample tick.
    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = tick_count + n;
        budget = n * 16 + 40;
        while (tick_count < target && budget > 0) begin
            @(negedge clk_in);
            sample_acc();
            budget--;
        end
        if (tick_count < target) check("wait_ticks_timeout", 32'(tick_count), 32'(target));
    endtask

    task automatic release_reset_with_tick_high();
        int budget;
        budget = 20;
        do begin
            @(negedge clk_in);
            #1;
            budget--;
        end while (tick_clk !== 1'b1 && budget > 0);
        if (tick_clk !== 1'b1) check("tick_high_timeout", 32'(tick_clk), 32'd1);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        steps[0] = '{4'b0001, 5, 4'b0001, 4'b0001, 4'b0000};
        steps[1] = '{4'b0000, 5, 4'b0000, 4'b0000, 4'b0001};
        steps[2] = '{4'b0101, 5, 4'b0101, 4'b0101, 4'b0000};
        steps[3] = '{4'b1101, 5, 4'b1101, 4'b1000, 4'b0000};
        steps[4] = '{4'b0010, 5, 4'b0010, 4'b0010, 4'b1101};
        steps[5] = '{4'b0000, 5, 4'b0000, 4'b0000, 4'b0010};

        reset_n = 1'b0;
        keys_in = '0;
        reset_acc();
        repeat (3) @(negedge clk_in);
        check("reset_state", 32'(keys_state), 32'd0);
        check("reset_press", 32'(keys_press), 32'd0);
        check("reset_release", 32'(keys_release), 32'd0);
        reset_n = 1'b1;

        // Reset mid-window clears everything at once; a held key needs a full new window.
        keys_in = 4'hF;
        wait_ticks(5);
        check("t1_pre_state", 32'(keys_state), 32'hF);
        keys_in = 4'h0;
        wait_ticks(2);
        keys_in = 4'hF;
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_state", 32'(keys_state), 32'd0);
        check("t1_async_press", 32'(keys_press), 32'd0);
        check("t1_async_release", 32'(keys_release), 32'd0);
        wait_cycles(4);
        release_reset_with_tick_high();
        reset_acc();
        wait_ticks(3);
        check("t1_before_4th_state", 32'(keys_state), 32'd0);
        check("t1_before_4th_press", 32'(acc_press), 32'd0);
        wait_ticks(1);
        check("t1_accept_state", 32'(keys_state), 32'hF);
        check("t1_accept_press", 32'(keys_press), 32'hF);
        wait_cycles(1);
        check("t1_press_cleared", 32'(keys_press), 32'd0);
        check("t1_pulse_cycles", 32'(pulse_cycles), 32'd1);
        keys_in = 4'h0;
        wait_ticks(5);
        check("t1_cleanup_state", 32'(keys_state), 32'd0);

        // Table: press, release, simultaneous and mixed press/release steps
        for (int i = 0; i < 6; i++) begin
            keys_in = steps[i].keys;
            reset_acc();
            wait_ticks(steps[i].ticks);
            check($sformatf("tbl%0d_state", i), 32'(keys_state), 32'(steps[i].exp_state));
            check($sformatf("tbl%0d_press", i), 32'(acc_press), 32'(steps[i].exp_press));
            check($sformatf("tbl%0d_release", i), 32'(acc_release), 32'(steps[i].exp_release));
            check($sformatf("tbl%0d_pulse_cycles", i), 32'(pulse_cycles), 32'd1);
        end

        // Bounce: high for 2 ticks, low for 1 tick never accumulates a full window
        reset_acc();
        repeat (13) begin
            keys_in = 4'b0010;
            wait_ticks(2);
            keys_in = 4'b0000;
            wait_ticks(1);
        end
        check("t3_bounce_state", 32'(keys_state), 32'd0);
        check("t3_bounce_press", 32'(acc_press), 32'd0);
        check("t3_bounce_release", 32'(acc_release), 32'd0);
        keys_in = 4'b0010;
        wait_ticks(3);
        check("t3_before_4th_state", 32'(keys_state), 32'd0);
        wait_ticks(1);
        check("t3_accept_state", 32'(keys_state), 32'b0010);
        check("t3_accept_press", 32'(keys_press), 32'b0010);
        check("t3_accept_release", 32'(keys_release), 32'd0);
        wait_cycles(1);
        check("t3_press_cleared", 32'(keys_press), 32'd0);
        keys_in = 4'b0000;
        wait_ticks(5);
        check("t3_cleanup_state", 32'(keys_state), 32'd0);

        // Stalled tick: no ticks, no acceptance, however long the key is held
        tick_stop = 1'b1;
        wait_cycles(2);
        keys_in = 4'hF;
        reset_acc();
        wait_cycles(1000);
        check("t6_stall_state", 32'(keys_state), 32'd0);
        check("t6_stall_press", 32'(acc_press), 32'd0);
        tick_stop = 1'b0;
        wait_ticks(3);
        check("t6_before_4th_state", 32'(keys_state), 32'd0);
        wait_ticks(1);
        check("t6_accept_state", 32'(keys_state), 32'hF);
        check("t6_accept_press", 32'(keys_press), 32'hF);
        keys_in = 4'h0;
        wait_ticks(5);
        check("t6_cleanup_state", 32'(keys_state), 32'd0);

        // Random key activity, occasional stalls and one reset, checked against the model
        for (int it = 0; it < 200; it++) begin
            keys_in   = 4'($urandom);
            tick_stop = ($urandom_range(0, 7) == 0);
            wait_cycles($urandom_range(1, 70));
            if (it == 100) begin
                #2 reset_n = 1'b0;
                wait_cycles(3);
                reset_n = 1'b1;
            end
        end
        tick_stop = 1'b0;
        wait_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
